bk_vid_fetch: RTL and testbench

Video-memory reader for the BK-0010 display path. It sits between the CPU/video RAM arbiter and the pixel shifter. During horizontal blanking it fetches the next displayed scanline (32 words) into a line buffer over a req/ack handshake. During the visible part of the line it presents one 16-bit word per 16 pixels, with a load strobe, to the shifter.

---
 rtl/bk_video_pkg.sv | 14 +
 rtl/bk_linebuf.sv | 35 +++
 rtl/bk_vid_fetch.sv | 119 +++++++++++
 tb/tb_bk_vid_fetch.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/bk_video_pkg.sv
// bk_video_pkg: shared timing constants, fill-state enum and row helper for the BK-0010 video fetch path
package bk_video_pkg;
    localparam logic [9:0] H_VISIBLE      = 10'd512;
    localparam logic [9:0] H_FETCH        = 10'd512;
    localparam logic [9:0] H_LAST         = 10'd699;
    localparam logic [9:0] V_LAST         = 10'd625;
    localparam logic [9:0] V_VISIBLE      = 10'd512;
    localparam int         WORDS_PER_LINE = 32;
    localparam logic [7:0] SCROLL_BASE    = 8'o330;
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT} fill_t;
    function automatic logic [7:0] row_of(input logic [7:0] sl, input logic [7:0] sc);
        return sl + sc - SCROLL_BASE;
    endfunction
endpackage

// File: rtl/bk_linebuf.sv
// bk_linebuf: 32x16 line buffer with per-word valid mask
// Ports: clk25/res_n (sync active-low); i_clr clears the whole valid mask;
// i_we/i_waddr/i_wdata write a word and mark it valid; i_re/i_raddr register
// o_rdata and its valid bit o_rvalid on the next edge.
module bk_linebuf
    import bk_video_pkg::*;
(
    input  logic        clk25,
    input  logic        res_n,
    input  logic        i_clr,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [15:0] i_wdata,
    input  logic        i_re,
    input  logic [4:0]  i_raddr,
    output logic [15:0] o_rdata,
    output logic        o_rvalid
);
    logic [15:0] r_mem [WORDS_PER_LINE];
    logic [WORDS_PER_LINE-1:0] r_valid;
    always_ff @(posedge clk25) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end
    // data survives reset; only the mask is cleared, so stale words read as zero
    always_ff @(posedge clk25) begin
        if (!res_n) begin
            r_valid  <= '0;
            o_rvalid <= 1'b0;
        end else begin
            r_valid <= (i_clr ? '0 : r_valid) | (i_we ? WORDS_PER_LINE'(1) << i_waddr : '0);
            if (i_re) o_rvalid <= r_valid[i_raddr];
        end
    end
endmodule

// File: rtl/bk_vid_fetch.sv
// bk_vid_fetch: fetches the next scanline during hblank and feeds one word per 16 pixels to the shifter
// Ports: clk25/res_n (sync active-low); x_i/y_i beam position; scroll_i scroll register;
// vreq_o/vaddr_o/vack_i/vdata_i video RAM read handshake; data_o/load_o shifter word and strobe;
// underrun_o sticky late-fill flag, cleared by underrun_clr_i.
// Macro BK_VIDEO_SCROLL_EN enables scroll offset and extended/full-screen mode.
module bk_vid_fetch
    import bk_video_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk25,
    input  logic        res_n,
    input  logic [9:0]  x_i,
    input  logic [9:0]  y_i,
    input  logic [9:0]  scroll_i,
    output logic        vreq_o,
    output logic [12:0] vaddr_o,
    input  logic        vack_i,
    input  logic [15:0] vdata_i,
    output logic [15:0] data_o,
    output logic        load_o,
    output logic        underrun_o,
    input  logic        underrun_clr_i
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    fill_t         r_state;
    logic [4:0]    r_widx;
    logic [7:0]    r_row;
    logic [TW-1:0] r_tmo;
    logic [9:0]    w_ny;
    logic [7:0]    w_sl, w_row;
    logic          w_blank, w_blank_cur, w_start, w_deadline, w_tmo_hit, w_adv, w_last;
    logic [15:0]   w_rdata;
    logic          w_rvalid;
    logic          w_unused;
    assign w_ny = (y_i == V_LAST) ? 10'd0 : y_i + 10'd1;
    assign w_sl = w_ny[8:1];
`ifdef BK_VIDEO_SCROLL_EN
    logic [7:0] r_scroll, w_scroll;
    logic       w_latch;
    assign w_latch     = x_i == H_FETCH && y_i == V_LAST;
    // the frame's first fetch happens on the latch cycle, so it sees the new value directly
    assign w_scroll    = w_latch ? scroll_i[7:0] : r_scroll;
    assign w_row       = row_of(w_sl, w_scroll);
    assign w_blank     = !scroll_i[9] && w_sl[7:6] != 2'b00;
    assign w_blank_cur = !scroll_i[9] && y_i[8:7] != 2'b00;
    assign w_unused    = scroll_i[8];
    always_ff @(posedge clk25) begin
        if (!res_n) r_scroll <= SCROLL_BASE;
        else if (w_latch) r_scroll <= scroll_i[7:0];
    end
`else
    assign w_row       = w_sl;
    assign w_blank     = 1'b0;
    assign w_blank_cur = 1'b0;
    assign w_unused    = ^scroll_i;
`endif
    assign w_start    = r_state == S_IDLE && x_i == H_FETCH && w_ny < V_VISIBLE && !w_blank;
    assign w_deadline = r_state == S_FETCH && x_i == H_LAST;
    assign w_tmo_hit  = r_tmo == TW'(ACK_TIMEOUT - 1);
    assign w_adv      = r_state == S_FETCH && !w_deadline && (vack_i || w_tmo_hit);
    assign w_last     = r_widx == 5'(WORDS_PER_LINE - 1);
    always_ff @(posedge clk25) begin
        if (!res_n) begin
            r_state    <= S_IDLE;
            r_widx     <= '0;
            r_row      <= '0;
            r_tmo      <= '0;
            vreq_o     <= 1'b0;
            vaddr_o    <= '0;
            underrun_o <= 1'b0;
        end else begin
            // a timeout advance without ack is a skipped word
            underrun_o <= (w_deadline || (w_adv && !vack_i)) ? 1'b1 : underrun_clr_i ? 1'b0 : underrun_o;
            if (w_start) begin
                r_state <= S_FETCH;
                r_widx  <= '0;
                r_row   <= w_row;
                r_tmo   <= '0;
                vreq_o  <= 1'b1;
                vaddr_o <= {w_row, 5'd0};
            end else if (w_deadline) begin
                r_state <= S_WAIT;
                vreq_o  <= 1'b0;
            end else if (w_adv) begin
                r_tmo   <= '0;
                r_widx  <= r_widx + 5'd1;
                vaddr_o <= {r_row, r_widx + 5'd1};
                if (w_last) begin
                    r_state <= S_IDLE;
                    vreq_o  <= 1'b0;
                end
            end else if (r_state == S_FETCH) r_tmo <= r_tmo + 1'b1;
            else if (r_state == S_WAIT) r_state <= S_IDLE;
        end
    end
    bk_linebuf u_buf (
        .clk25   (clk25),
        .res_n   (res_n),
        .i_clr   (w_start),
        .i_we    (r_state == S_FETCH && vack_i),
        .i_waddr (r_widx),
        .i_wdata (vdata_i),
        .i_re    (x_i[3:0] == 4'd13),
        .i_raddr (x_i[8:4]),
        .o_rdata (w_rdata),
        .o_rvalid(w_rvalid)
    );
    always_ff @(posedge clk25) begin
        if (!res_n) begin
            data_o <= '0;
            load_o <= 1'b0;
        end else begin
            load_o <= x_i[3:0] == 4'd14;
            if (x_i[3:0] == 4'd14)
                data_o <= (x_i < H_VISIBLE && y_i < V_VISIBLE && !w_blank_cur && w_rvalid) ? w_rdata : 16'h0;
        end
    end
endmodule

// File: tb/tb_bk_vid_fetch.sv
// tb_bk_vid_fetch: directed line-by-line bench for bk_vid_fetch with a simple video RAM arbiter model
module tb_bk_vid_fetch;
`ifdef BK_VIDEO_SCROLL_EN
    localparam bit SCROLL_EN = 1'b1;
`else
    localparam bit SCROLL_EN = 1'b0;
`endif
    logic        clk25 = 1'b0;
    logic        res_n;
    logic [9:0]  x_i, y_i, scroll_i;
    logic        vreq_o;
    logic [12:0] vaddr_o;
    logic        vack_i = 1'b0;
    logic [15:0] vdata_i = '0;
    logic [15:0] data_o;
    logic        load_o, underrun_o, underrun_clr_i;
    int          errors = 0;
    int          checks = 0;
    int          ack_wait = 0;
    int          wcnt = 0;
    logic [15:0] exp_w [32];
    logic [7:0]  lat_m = 8'o330;
    logic        v513, v521, v545, u600, u_end;
    logic [12:0] a513;

    bk_vid_fetch dut (
        .clk25         (clk25),
        .res_n         (res_n),
        .x_i           (x_i),
        .y_i           (y_i),
        .scroll_i      (scroll_i),
        .vreq_o        (vreq_o),
        .vaddr_o       (vaddr_o),
        .vack_i        (vack_i),
        .vdata_i       (vdata_i),
        .data_o        (data_o),
        .load_o        (load_o),
        .underrun_o    (underrun_o),
        .underrun_clr_i(underrun_clr_i)
    );

    always #20 clk25 = ~clk25;

    // arbiter: acks every (ack_wait+1)-th request cycle, RAM word at address a holds a
    always @(negedge clk25) begin
        if (vreq_o && wcnt >= ack_wait) begin
            vack_i = 1'b1;
            wcnt = 0;
        end else begin
            vack_i = 1'b0;
            wcnt = vreq_o ? wcnt + 1 : 0;
        end
        vdata_i = {3'b0, vaddr_o};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] row(input logic [7:0] sl);
        return SCROLL_EN ? sl + lat_m - 8'o330 : sl;
    endfunction

    task automatic set_exp(input int sl, input int n);
        int base;
        base = int'(row(8'(sl))) * 32;
        for (int i = 0; i < 32; i++) exp_w[i] = (i < n) ? 16'(base + i) : 16'h0;
    endtask

    task automatic run_line(input int y, input int rst_x, input string tag);
        for (int x = 0; x < 700; x++) begin
            @(negedge clk25);
            x_i = 10'(x);
            y_i = 10'(y);
            res_n = (x != rst_x);
            check($sformatf("%s load x=%0d", tag, x), load_o, (x % 16 == 15) ? 1 : 0);
            if (x % 16 == 15)
                check($sformatf("%s data x=%0d", tag, x), data_o, (x < 512) ? exp_w[x / 16] : 16'h0);
            if (x == 513) begin
                v513 = vreq_o;
                a513 = vaddr_o;
            end
            if (x == 521) v521 = vreq_o;
            if (x == 545) v545 = vreq_o;
            if (x == 600) u600 = underrun_o;
        end
        @(negedge clk25);
        u_end = underrun_o;
    endtask

    initial begin
        res_n = 1'b0;
        x_i = '0;
        y_i = '0;
        scroll_i = 10'o1330;
        underrun_clr_i = 1'b0;
        repeat (3) @(negedge clk25);
        check("rst vreq", vreq_o, 0);
        check("rst vaddr", vaddr_o, 0);
        check("rst data", data_o, 0);
        check("rst load", load_o, 0);
        check("rst underrun", underrun_o, 0);

        set_exp(0, 0);
        run_line(1, -1, "l1");
        check("l1 vreq@513", v513, 1);
        check("l1 vaddr@513", a513, 32);
        check("l1 vreq@545", v545, 0);
        check("l1 underrun", u_end, 0);
        set_exp(1, 32);
        run_line(2, -1, "l2");

        scroll_i = 10'o0330;
        run_line(127, -1, "l127");
        check("l127 vreq@513", v513, SCROLL_EN ? 0 : 1);
        if (SCROLL_EN) set_exp(0, 0);
        else set_exp(64, 32);
        run_line(128, -1, "l128");

        scroll_i = 10'o1331;
        set_exp(0, 0);
        run_line(625, -1, "l625");
        lat_m = 8'o331;
        set_exp(0, 32);
        run_line(0, -1, "l0");
        run_line(510, -1, "l510");
        check("l510 vreq@513", v513, 1);
        set_exp(255, 32);
        run_line(511, -1, "l511");
        check("l511 vreq@513", v513, 0);

        ack_wait = 100000;
        run_line(3, -1, "l3");
        check("l3 vreq@513", v513, 1);
        check("l3 underrun", u_end, 1);
        ack_wait = 0;
        set_exp(0, 0);
        run_line(4, -1, "l4");
        check("l4 underrun sticky", u_end, 1);
        @(negedge clk25);
        underrun_clr_i = 1'b1;
        @(negedge clk25);
        underrun_clr_i = 1'b0;
        check("underrun clear", underrun_o, 0);

        ack_wait = 7;
        set_exp(2, 32);
        run_line(5, -1, "l5");
        check("l5 underrun@600", u600, 0);
        check("l5 underrun end", u_end, 1);
        ack_wait = 0;
        set_exp(3, 23);
        run_line(6, -1, "l6");

        set_exp(3, 32);
        run_line(7, 520, "l7");
        check("l7 vreq after reset", v521, 0);
        check("l7 underrun after reset", u_end, 0);
        lat_m = 8'o330;
        set_exp(0, 0);
        run_line(8, -1, "l8");
        check("l8 underrun", u_end, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
